// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-granting arbiter driving the async FIFO write port (winc/wdata) in the wclk domain.
// Arbitration takes one IDLE cycle; beats then flow combinationally while wfull is low, stalling in place when it is high.
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 4
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wfull,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    busy
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(MAXBURST + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]    state;
  logic [GW-1:0] rr_ptr;
  logic [CW-1:0] beat_cnt;
  logic [GW-1:0] pick;
  logic          found;
  int            idx;
  logic          at_max;

  // First valid requester after the previous winner, wrapping modulo NREQ.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  assign at_max    = (beat_cnt == CW'(MAXBURST - 1));
  assign busy      = (state == S_GRANT);
  assign winc      = busy && req_valid[gnt_id] && !wfull;
  assign req_ready = (busy && !wfull) ? (NREQ'(1) << gnt_id) : '0;
  assign wdata     = busy ? req_data[int'(gnt_id)*DSIZE +: DSIZE] : '0;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= GW'(NREQ - 1);
      gnt_id   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            gnt_id   <= pick;
            beat_cnt <= '0;
            state    <= S_GRANT;
          end
        end
        default: begin
          // A full FIFO freezes the grant entirely, even if valid drops meanwhile.
          if (!wfull) begin
            if (req_valid[gnt_id]) begin
              if (req_last[gnt_id] || at_max) begin
                state  <= S_IDLE;
                rr_ptr <= gnt_id;
              end else begin
                beat_cnt <= beat_cnt + CW'(1);
              end
            end else begin
              state  <= S_IDLE;
              rr_ptr <= gnt_id;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-cycle comparison against a grant/burst model, directed
// scenarios with literal write traces, then a long randomized run.
module tb_fifo_wr_arbiter;

  localparam int NREQ     = 4;
  localparam int DSIZE    = 8;
  localparam int MAXBURST = 4;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [1:0]            gnt_id;
  logic                  busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the arbiter: who holds the port, who won last, beats moved this grant.
  bit m_grant;
  int m_gnt, m_rr, m_beats;

  // Requester side: queued beats {last, data}, optional valid drop per requester.
  logic [8:0]  beatq [NREQ][$];
  bit          hold_off [NREQ];
  bit          last_xfer;
  int          last_xfer_id;
  int          step_no;
  logic [23:0] trace[$];
  logic [23:0] exp_t[$];
  logic        s_winc;
  logic [3:0]  s_ready;
  logic [1:0]  s_gnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (step %0d, t=%0t)", name, act, exp, step_no, $time);
  endtask

  task automatic model_reset();
    m_grant = 0; m_rr = NREQ - 1; m_gnt = 0; m_beats = 0;
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (beatq[i].size() > 0) begin
        req_valid[i]            = !hold_off[i];
        req_data[i*DSIZE +: 8]  = beatq[i][0][7:0];
        req_last[i]             = beatq[i][0][8];
      end else begin
        req_valid[i]            = 1'b0;
        req_data[i*DSIZE +: 8]  = 8'h00;
        req_last[i]             = 1'b0;
      end
    end
  endtask

  task automatic retire();
    if (last_xfer) void'(beatq[last_xfer_id].pop_front());
  endtask

  task automatic push_burst(input int r, input int base, input int n, input bit with_last);
    for (int k = 0; k < n; k++) beatq[r].push_back({with_last && (k == n - 1), 8'(base + k)});
  endtask

  // Compare outputs with the model, log the write, advance the model one clock.
  task automatic step();
    logic       e_winc;
    logic [3:0] e_ready;
    bit         found;
    #1;
    e_winc  = m_grant && req_valid[m_gnt] && !wfull;
    e_ready = (m_grant && !wfull) ? (4'b0001 << m_gnt) : 4'b0000;
    check("busy", busy, m_grant);
    check("winc", winc, e_winc);
    check("req_ready", req_ready, e_ready);
    check("gnt_id", gnt_id, m_gnt);
    if (m_grant) check("wdata", wdata, req_data[m_gnt*DSIZE +: 8]);
    s_winc = winc; s_ready = req_ready; s_gnt = gnt_id;
    if (winc) trace.push_back({8'(step_no), 6'd0, gnt_id, wdata});
    last_xfer = e_winc; last_xfer_id = m_gnt;
    if (!m_grant) begin
      found = 0;
      for (int k = 1; k <= NREQ; k++) begin
        if (!found && req_valid[(m_rr + k) % NREQ]) begin
          found = 1; m_gnt = (m_rr + k) % NREQ;
        end
      end
      if (found) begin m_grant = 1; m_beats = 0; end
    end else if (!wfull) begin
      if (req_valid[m_gnt]) begin
        m_beats++;
        if (req_last[m_gnt] || m_beats == MAXBURST) begin m_grant = 0; m_rr = m_gnt; end
      end else begin
        m_grant = 0; m_rr = m_gnt;
      end
    end
    step_no++;
    @(negedge wclk);
  endtask

  task automatic step_feed();
    step(); retire(); apply_inputs();
  endtask

  task automatic do_reset();
    @(negedge wclk);
    wrst_n = 1'b0; wfull = 1'b0;
    for (int i = 0; i < NREQ; i++) begin beatq[i].delete(); hold_off[i] = 0; end
    apply_inputs();
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_winc", winc, 1'b0);
    check("rst_ready", req_ready, 4'b0000);
    check("rst_gnt_id", gnt_id, 2'd0);
    model_reset();
    step_no = 0; trace.delete(); last_xfer = 0;
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  task automatic check_trace(input string name);
    check({name, "_len"}, trace.size(), exp_t.size());
    for (int i = 0; i < exp_t.size(); i++)
      if (i < trace.size()) check(name, trace[i], exp_t[i]);
  endtask

  initial begin
    int stall;
    wrst_n = 1'b0; wfull = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    model_reset();
    repeat (2) @(negedge wclk);

    // Single requester, 3-beat burst: one arbitration cycle, then back-to-back writes.
    do_reset();
    push_burst(0, 8'hA0, 3, 1); apply_inputs();
    repeat (5) step_feed();
    exp_t = {24'h0100A0, 24'h0200A1, 24'h0300A2};
    check_trace("t1_trace");

    // Two requesters of single-beat bursts alternate.
    do_reset();
    for (int k = 0; k < 4; k++) begin push_burst(0, k, 1, 1); push_burst(2, 8'h20 + k, 1, 1); end
    apply_inputs();
    repeat (17) step_feed();
    exp_t = {24'h010000, 24'h030220, 24'h050001, 24'h070221,
             24'h090002, 24'h0B0222, 24'h0D0003, 24'h0F0223};
    check_trace("t2_trace");

    // Unterminated long burst is rotated every MAXBURST beats.
    do_reset();
    push_burst(1, 8'h10, 10, 0); push_burst(3, 8'h30, 2, 1); apply_inputs();
    repeat (18) step_feed();
    exp_t = {24'h010110, 24'h020111, 24'h030112, 24'h040113, 24'h060330, 24'h070331,
             24'h090114, 24'h0A0115, 24'h0B0116, 24'h0C0117, 24'h0E0118, 24'h0F0119};
    check_trace("t3_trace");

    // Five full cycles after the second beat freeze the grant.
    do_reset();
    push_burst(0, 8'h40, 6, 1); apply_inputs();
    stall = 0;
    repeat (15) begin
      if (trace.size() == 2 && stall < 5) begin wfull = 1'b1; stall++; end
      else wfull = 1'b0;
      step_feed();
      if (wfull) begin
        check("t4_stall_winc", s_winc, 1'b0);
        check("t4_stall_ready", s_ready, 4'b0000);
        check("t4_stall_gnt", s_gnt, 2'd0);
      end
    end
    wfull = 1'b0;
    exp_t = {24'h010040, 24'h020041, 24'h080042, 24'h090043, 24'h0B0044, 24'h0C0045};
    check_trace("t4_trace");

    // Valid drop releases the grant; the next search starts after the dropper.
    do_reset();
    push_burst(2, 8'h50, 2, 0); apply_inputs();
    repeat (13) begin
      step(); retire();
      if (step_no == 1) push_burst(1, 8'h60, 5, 1);
      apply_inputs();
    end
    exp_t = {24'h010250, 24'h020251, 24'h050160, 24'h060161,
             24'h070162, 24'h080163, 24'h0A0164};
    check_trace("t5_trace");

    // Asynchronous reset in the middle of a burst.
    do_reset();
    push_burst(0, 8'h70, 4, 1); apply_inputs();
    repeat (2) step_feed();
    #1 wrst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_winc", winc, 1'b0);
    check("t6_rst_ready", req_ready, 4'b0000);
    model_reset();
    for (int i = 0; i < NREQ; i++) beatq[i].delete();
    push_burst(1, 8'h81, 1, 1); push_burst(3, 8'h83, 1, 1);
    @(negedge wclk);
    wrst_n = 1'b1; step_no = 0; trace.delete(); last_xfer = 0;
    apply_inputs();
    repeat (5) step_feed();
    exp_t = {24'h010181, 24'h030383};
    check_trace("t6_trace");

    // Randomized traffic: bursts with and without last, valid drops, full flag noise.
    do_reset();
    apply_inputs();
    repeat (3000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (beatq[i].size() == 0 && $urandom_range(3) == 0)
          push_burst(i, $urandom_range(255), $urandom_range(7, 1), $urandom_range(3) != 0);
        if ($urandom_range(15) == 0) hold_off[i] = !hold_off[i];
      end
      wfull = ($urandom_range(4) == 0);
      apply_inputs();
      step();
      retire();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
